// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch (I) and memory-stage (D) requesters.
// Optional starvation guard for the I-side is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       decide, grant_i, grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] sc;
`endif

  // The ready cycle is IDLE but never a decision cycle, which spaces issues MEM_LAT+3 apart.
  assign decide  = (state == IDLE) && !i_ready && !d_ready;
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (decide) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (i_req && (!d_req || sc == SMAX)) grant_i = 1'b1;
      else if (d_req)                      grant_d = 1'b1;
`else
      if (d_req)      grant_d = 1'b1;
      else if (i_req) grant_i = 1'b1;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = D_BUSY;
        else if (grant_i) state_nxt = I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      mem_en  <= grant_i | grant_d;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        cnt       <= LAT;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
        cnt       <= LAT;
      end else if (state != IDLE) begin
        if (cnt == '0) begin
          if (state == I_BUSY) begin
            i_rdata <= mem_rdata;
            i_ready <= 1'b1;
          end else begin
            d_ready <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  // sc counts D grants that overtook a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc <= '0;
    end else if (grant_i) begin
      sc <= '0;
    end else if (grant_d) begin
      if (!i_req)         sc <= '0;
      else if (sc != SMAX) sc <= sc + 4'd1;
    end
  end
`endif

endmodule
